// File: rtl/jtag_scan_master.sv
// JTAG scan master: drives tck/tms/tdi at half the clk rate, walks the TAP through
// an IR or DR scan of up to MAX_LEN bits and captures tdo into rx_data.
module jtag_scan_master #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4  // must hold MAX_LEN and be at least 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_ir,
    input  logic [LEN_W-1:0]   length,
    input  logic [MAX_LEN-1:0] tx_data,
    input  logic               tdo,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    output logic [MAX_LEN-1:0] rx_data,
    output logic               busy,
    output logic               done,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        PRE   = 3'd2,
        SHIFT = 3'd3,
        POST  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Handshake: start is taken only in IDLE (busy=0); busy then stays high until the
    // scan finishes, done pulses for one clk with busy low, and rx_data is then valid.
    state_t             state, state_n;
    logic [LEN_W-1:0]   cnt, cnt_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic               ir_q, ir_n;
    logic [MAX_LEN-1:0] tx_q, tx_n;
    logic [MAX_LEN-1:0] rx_n;
    logic               tck_n, tms_n, tdi_n, busy_n, done_n;
    logic [LEN_W-1:0]   len_clamp;
    logic [LEN_W-1:0]   pre_last;

    assign len_clamp = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
    assign pre_last  = ir_q ? LEN_W'(3) : LEN_W'(2);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= INIT;
            cnt     <= '0;
            len_q   <= '0;
            ir_q    <= 1'b0;
            tx_q    <= '0;
            rx_data <= '0;
            tck     <= 1'b0;
            tms     <= 1'b1;
            tdi     <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            len_q   <= len_n;
            ir_q    <= ir_n;
            tx_q    <= tx_n;
            rx_data <= rx_n;
            tck     <= tck_n;
            tms     <= tms_n;
            tdi     <= tdi_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // tck=0 is the L phase; the edge ending an H phase samples tdo and sets up the next period.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len_q;
        ir_n    = ir_q;
        tx_n    = tx_q;
        rx_n    = rx_data;
        tck_n   = tck;
        tms_n   = tms;
        tdi_n   = tdi;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            INIT: begin
                if (!tck) begin
                    tck_n = 1'b1;
                end else begin
                    tck_n = 1'b0;
                    if (cnt == LEN_W'(5)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        tms_n   = 1'b0;
                        busy_n  = 1'b0;
                    end else begin
                        cnt_n = cnt + LEN_W'(1);
                        tms_n = (cnt < LEN_W'(4));
                    end
                end
            end
            IDLE: begin
                if (start) begin
                    state_n = PRE;
                    cnt_n   = '0;
                    ir_n    = is_ir;
                    len_n   = len_clamp;
                    tx_n    = tx_data;
                    rx_n    = '0;
                    busy_n  = 1'b1;
                    tms_n   = (len_clamp != '0);
                end
            end
            PRE: begin
                if (len_q == '0) begin
                    state_n = DONE;
                    tms_n   = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (!tck) begin
                    tck_n = 1'b1;
                end else begin
                    tck_n = 1'b0;
                    if (cnt == pre_last) begin
                        state_n = SHIFT;
                        cnt_n   = '0;
                        tms_n   = (len_q == LEN_W'(1));
                        tdi_n   = tx_q[0];
                        tx_n    = tx_q >> 1;
                    end else begin
                        cnt_n = cnt + LEN_W'(1);
                        tms_n = ir_q && (cnt == '0);
                    end
                end
            end
            SHIFT: begin
                if (!tck) begin
                    tck_n = 1'b1;
                end else begin
                    tck_n = 1'b0;
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (cnt == LEN_W'(i)) rx_n[i] = tdo;
                    end
                    if (cnt == len_q - LEN_W'(1)) begin
                        state_n = POST;
                        cnt_n   = '0;
                        tms_n   = 1'b1;
                        tdi_n   = 1'b0;
                    end else begin
                        cnt_n = cnt + LEN_W'(1);
                        tms_n = (cnt + LEN_W'(1) == len_q - LEN_W'(1));
                        tdi_n = tx_q[0];
                        tx_n  = tx_q >> 1;
                    end
                end
            end
            POST: begin
                if (!tck) begin
                    tck_n = 1'b1;
                end else begin
                    tck_n = 1'b0;
                    tms_n = 1'b0;
                    if (cnt == LEN_W'(1)) begin
                        state_n = DONE;
                        cnt_n   = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = LEN_W'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a behavioural TAP target plus table and random scans,
// each judged against a bit-stream reference of what the target should shift out and keep.
module tb_jtag_scan_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       is_ir = 1'b0;
  logic [3:0] length = '0;
  logic [7:0] tx_data = '0;
  logic       tdo = 1'b0;
  logic       tck, tms, tdi, busy, done;
  logic [7:0] rx_data;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;

  jtag_scan_master #(.MAX_LEN(8), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .is_ir(is_ir), .length(length),
    .tx_data(tx_data), .tdo(tdo), .tck(tck), .tms(tms), .tdi(tdi),
    .rx_data(rx_data), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- TAP target model ----------------
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDDR,
                    SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPDIR} tap_t;
  tap_t       tap = TLR;
  logic [7:0] dr_sr = '0, dr_reg = '0;
  logic [1:0] ir_sr = '0, ir_reg = '0;
  bit         tms_log[$];
  int         tck_rises = 0;

  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDDR : PSDR;
      PSDR:  return m ? EX2DR : PSDR;
      EX2DR: return m ? UPDDR : SHDR;
      UPDDR: return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPDIR : PSIR;
      PSIR:  return m ? EX2IR : PSIR;
      EX2IR: return m ? UPDIR : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    if (tap == CAPDR) dr_sr = 8'h3C;
    if (tap == CAPIR) ir_sr = 2'b01;
    if (tap == SHDR)  dr_sr = {tdi, dr_sr[7:1]};
    if (tap == SHIR)  ir_sr = {tdi, ir_sr[1]};
    tms_log.push_back(tms);
    tck_rises++;
    tap = tap_next(tap, tms);
  end

  always @(negedge tck) begin
    if (tap == UPDDR) dr_reg = dr_sr;
    if (tap == UPDIR) ir_reg = ir_sr;
    tdo = (tap == SHDR) ? dr_sr[0] : (tap == SHIR) ? ir_sr[0] : 1'b0;
  end

  // tms/tdi may only move on the edge that drops tck into an L phase
  int   phase_viol = 0;
  int   done_cnt = 0;
  logic p_tms = 1'b1, p_tdi = 1'b0;
  always @(negedge clk) begin
    if (!reset && tck && (tms !== p_tms || tdi !== p_tdi)) phase_viol++;
    if (done) done_cnt++;
    p_tms = tms;
    p_tdi = tdi;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tms_ref(bit ir, int n);
    logic [31:0] v = '0;
    int k;
    if (n == 0) return v;
    v[0] = 1'b1;
    if (ir) v[1] = 1'b1;
    k = ir ? 4 : 3;
    for (int i = 0; i < n; i++) v[k+i] = (i == n - 1);
    v[k+n] = 1'b1;
    return v;
  endfunction

  // Target shifts out its capture value then whatever was sent in; it keeps the last
  // reg-width bits of that stream once the scan updates.
  task automatic ref_scan(input bit ir, input int len, input logic [7:0] tx,
                          output logic [7:0] rx, output logic [7:0] rg, output int clks);
    int n = (len > 8) ? 8 : len;
    int w = ir ? 2 : 8;
    logic [7:0] cap = ir ? 8'h01 : 8'h3C;
    logic stream[0:15];
    for (int k = 0; k < 16; k++) stream[k] = 1'b0;
    for (int k = 0; k < w; k++) stream[k] = cap[k];
    for (int k = 0; k < n; k++) stream[w+k] = tx[k];
    rx = '0;
    for (int i = 0; i < n; i++) rx[i] = stream[i];
    rg = ir ? {6'b0, ir_reg} : dr_reg;
    if (n > 0) begin
      rg = '0;
      for (int j = 0; j < w; j++) rg[j] = stream[n+j];
    end
    clks = (n == 0) ? 1 : 2 * (n + (ir ? 6 : 5));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_init(input string tag);
    int clks = 0;
    tms_log.delete();
    while (clks < 60) begin
      @(posedge clk);
      clks++;
      @(negedge clk);
      if (!busy) break;
    end
    start = 1'b0;
    check({tag, "_init_clks"}, clks, 12);
    check({tag, "_init_tms"}, {tms_log.size() == 6, tms_log[0], tms_log[1], tms_log[2],
                               tms_log[3], tms_log[4], tms_log[5]}, 7'b1111110);
    check({tag, "_init_tap"}, tap, RTI);
    @(negedge clk);
    check({tag, "_idle_state"}, {busy, dbg_state}, {1'b0, 3'd1});
  endtask

  task automatic run_scan(input string tag, input bit ir, input int len, input logic [7:0] tx,
                          input logic [7:0] exp_rx, input logic [7:0] exp_rg,
                          input int exp_clks, input bit hold);
    int clks = 0;
    int n = (len > 8) ? 8 : len;
    logic [31:0] act_tms = '0;
    @(negedge clk);
    start = 1'b1; is_ir = ir; length = 4'(len); tx_data = tx;
    @(posedge clk);
    tms_log.delete();
    tck_rises = 0;
    @(negedge clk);
    if (!hold) start = 1'b0;
    tx_data = 8'($urandom);
    length = 4'($urandom);
    check({tag, "_busy"}, busy, 1'b1);
    while (clks < 200) begin
      @(posedge clk);
      clks++;
      @(negedge clk);
      if (done) break;
    end
    start = 1'b0;
    foreach (tms_log[i]) if (i < 32) act_tms[i] = tms_log[i];
    check({tag, "_clks"}, clks, exp_clks);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_periods"}, tck_rises, (n == 0) ? 0 : n + (ir ? 6 : 5));
    check({tag, "_tms_seq"}, act_tms, tms_ref(ir, n));
    check({tag, "_rx"}, rx_data, exp_rx);
    @(negedge clk);
    check({tag, "_done_width"}, {done, busy}, 2'b00);
    check({tag, "_rx_hold"}, rx_data, exp_rx);
    check({tag, "_target_reg"}, ir ? {6'b0, ir_reg} : dr_reg, exp_rg);
    check({tag, "_tap_rti"}, tap, RTI);
  endtask

  typedef struct {
    bit         is_ir;
    int         len;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_rg;
    int         exp_clks;
  } vec_t;

  initial begin
    vec_t vecs[5];
    logic [7:0] erx, erg;
    int eclk, dc;
    bit ir;
    int len;
    logic [7:0] tx;

    vecs[0] = '{1'b0, 8,  8'hA5, 8'h3C, 8'hA5, 26};
    vecs[1] = '{1'b1, 2,  8'h02, 8'h01, 8'h02, 16};
    vecs[2] = '{1'b0, 0,  8'hFF, 8'h00, 8'hA5, 1};
    vecs[3] = '{1'b0, 12, 8'hC3, 8'h3C, 8'hC3, 26};
    vecs[4] = '{1'b0, 3,  8'h05, 8'h04, 8'hA7, 16};

    // reset values and first INIT
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {tck, tms, tdi, busy, done}, 5'b01010);
    check("reset_rx", rx_data, 8'h00);
    check("reset_state", dbg_state, 3'd0);
    reset = 1'b0;
    wait_init("first");

    foreach (vecs[i]) begin
      run_scan($sformatf("vec%0d", i), vecs[i].is_ir, vecs[i].len, vecs[i].tx,
               vecs[i].exp_rx, vecs[i].exp_rg, vecs[i].exp_clks, 1'b0);
    end

    for (int r = 0; r < 20; r++) begin
      ir  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 12);
      tx  = 8'($urandom);
      ref_scan(ir, len, tx, erx, erg, eclk);
      run_scan($sformatf("rand%0d", r), ir, len, tx, erx, erg, eclk, 1'b0);
    end

    // start held high across a whole scan, including the DONE cycle
    ref_scan(1'b0, 5, 8'h9B, erx, erg, eclk);
    run_scan("hold", 1'b0, 5, 8'h9B, erx, erg, eclk, 1'b1);
    repeat (2) @(negedge clk);
    check("hold_no_restart", {busy, dbg_state}, {1'b0, 3'd1});

    // reset while the 5th shift bit is on the wire, start held high throughout
    @(negedge clk);
    start = 1'b1; is_ir = 1'b0; length = 4'd8; tx_data = 8'h5A;
    @(posedge clk);
    repeat (14) @(posedge clk);
    #1;
    check("abort_in_shift", dbg_state, 3'd3);
    dc = done_cnt;
    #1 reset = 1'b1;
    #1;
    check("abort_outputs", {tck, tms, tdi, busy, done}, 5'b01010);
    check("abort_rx", rx_data, 8'h00);
    check("abort_state", dbg_state, 3'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_init("rerun");
    check("abort_no_done", done_cnt, dc);

    ref_scan(1'b1, 4, 8'h0E, erx, erg, eclk);
    run_scan("after_abort", 1'b1, 4, 8'h0E, erx, erg, eclk, 1'b0);

    check("phase_rule", phase_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
